// File: rtl/mips_memory_responder_if.sv
// Data-memory bus between the core's memory cache (master) and main memory (slave).
// Byte lanes are unpacked [0:3]; lane i maps to byte address word_base+i.
interface mips_memory_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_addr;
  logic [7:0]      mem_data_in  [0:3];
  logic            mem_write_en;
  logic [7:0]      mem_data_out [0:3];
  logic            mem_ready;
  logic            mem_error;

  modport master (
    output mem_addr, mem_data_in, mem_write_en,
    input  mem_data_out, mem_ready, mem_error
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en,
    output mem_data_out, mem_ready, mem_error
  );
endinterface

// File: rtl/mips_memory_responder.sv
// Fixed-latency, byte-addressed little-endian word memory answering the cache's data bus.
// A request completes LATENCY edges after capture; any change in the request restarts it.
module mips_memory_responder #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      rst_b,
  mips_memory_responder_if.slave    bus
);
  localparam int         WORDS      = 2 ** (ADDR_BITS - 2);
  localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

  typedef enum logic {ST_WAIT, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:2] req_addr_q, req_addr_d;
  logic            req_we_q, req_we_d;
  logic [31:0]     req_wdata_q, req_wdata_d;
  logic            req_valid_q, req_valid_d;
  logic [3:0]      count_q, count_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;

  logic [31:0]          in_wdata;
  logic                 new_req;
  logic                 complete;
  logic                 req_in_range;
  logic                 commit_wr;
  logic                 commit_rd;
  logic [ADDR_BITS-3:0] word_idx;
  logic                 unused_addr_bits;

  genvar gi;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign in_wdata[8*gi +: 8] = bus.mem_data_in[gi];
    end
  endgenerate

  assign unused_addr_bits = ^bus.mem_addr[1:0];

  // Write data only participates in the tuple for writes; read lanes are don't-care.
  assign new_req = !req_valid_q
                || (bus.mem_addr[XLEN-1:2] != req_addr_q)
                || (bus.mem_write_en != req_we_q)
                || (bus.mem_write_en && (in_wdata != req_wdata_q));

  assign req_in_range = (req_addr_q[XLEN-1:ADDR_BITS] == '0);
  assign word_idx     = req_addr_q[ADDR_BITS-1:2];
  assign complete     = !new_req && (state_q == ST_WAIT) && (count_q == LAST_COUNT);
  assign commit_wr    = complete && req_we_q && req_in_range && !rst_b;
  assign commit_rd    = complete && !req_we_q && !rst_b;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_valid_d = req_valid_q;
    count_d     = count_q;
    ready_d     = ready_q;
    error_d     = error_q;
    if (new_req) begin
      state_d     = ST_WAIT;
      req_addr_d  = bus.mem_addr[XLEN-1:2];
      req_we_d    = bus.mem_write_en;
      req_wdata_d = in_wdata;
      req_valid_d = 1'b1;
      count_d     = 4'd0;
      ready_d     = 1'b0;
      error_d     = (bus.mem_addr[XLEN-1:ADDR_BITS] != '0);
    end else if (state_q == ST_WAIT) begin
      if (count_q == LAST_COUNT) begin
        state_d = ST_DONE;
        ready_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= ST_WAIT;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_valid_q <= 1'b0;
      count_q     <= 4'd0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_valid_q <= req_valid_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_error = error_q;

  // One byte-wide RAM per lane so a word access touches each lane once.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [WORDS];
      logic [7:0] rdata_q;

      always_ff @(posedge clk) begin
        if (commit_wr) begin
          ram[word_idx] <= req_wdata_q[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst_b) begin
          rdata_q <= 8'h00;
        end else if (commit_rd) begin
          rdata_q <= req_in_range ? ram[word_idx] : 8'h00;
        end
      end

      assign bus.mem_data_out[gi] = rdata_q;
    end
  endgenerate
endmodule
